// File: rtl/ppu_pkg.sv
// Shared int8 type, saturation bounds and signed max helper for the ppu_stream datapath.
package ppu_pkg;

  typedef logic signed [7:0] qint8_t;

  localparam int QMIN = -128;
  localparam int QMAX = 127;

  function automatic qint8_t qmax(input qint8_t a, input qint8_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppu_quant_lane.sv
// One-lane requantiser: arithmetic right shift with int8 saturation.
// Optional round half-up before the shift when PPU_ROUND_EN is defined.
module ppu_quant_lane
  import ppu_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int SHIFT_W   = 6
) (
  input  logic [DATA_BITS-1:0] data_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  output logic [7:0]           q_o
);

  localparam logic signed [DATA_BITS:0] SAT_HI = (DATA_BITS+1)'(QMAX);
  localparam logic signed [DATA_BITS:0] SAT_LO = (DATA_BITS+1)'(QMIN);

  logic signed [DATA_BITS:0] ext;
  logic signed [DATA_BITS:0] shifted;

`ifdef PPU_ROUND_EN
  logic signed [DATA_BITS:0] bias;

  // Half an output LSB, wrapping in DATA_BITS+1 bits like the datapath itself.
  always_comb begin
    bias = '0;
    if (shift_i != '0) bias = (DATA_BITS+1)'(1) << (shift_i - SHIFT_W'(1));
  end

  assign ext = $signed({data_i[DATA_BITS-1], data_i}) + bias;
`else
  assign ext = $signed({data_i[DATA_BITS-1], data_i});
`endif

  assign shifted = ext >>> shift_i;

  always_comb begin
    if (shifted > SAT_HI) begin
      q_o = 8'(QMAX);
    end else if (shifted < SAT_LO) begin
      q_o = 8'(QMIN);
    end else begin
      q_o = shifted[7:0];
    end
  end

endmodule

// File: rtl/ppu_stream.sv
// Multi-lane streaming post-processing unit: requantise, optional max-pool over L beats, optional ReLU.
// Rounding mode is selected at build time with PPU_ROUND_EN.
module ppu_stream
  import ppu_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DATA_BITS = 32,
  parameter int SHIFT_W   = 6,
  parameter int MAX_POOL  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_BITS-1:0]       in_data,
  input  logic [SHIFT_W-1:0]               scaling_factor,
  input  logic                             maxpool_en,
  input  logic [$clog2(MAX_POOL+1)-1:0]    pool_len,
  input  logic                             relu_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*8-1:0]               out_data
);

  localparam int PL_W = $clog2(MAX_POOL+1);

  qint8_t             q_lane [LANES];
  qint8_t             s1_q   [LANES];
  qint8_t             s1_d   [LANES];
  qint8_t             acc_q  [LANES];
  qint8_t             acc_d  [LANES];
  qint8_t             pooled [LANES];
  logic               s1_valid_q, s1_valid_d;
  logic               out_valid_q, out_valid_d;
  logic [LANES*8-1:0] out_data_q, out_data_d;
  logic [PL_W-1:0]    cnt_q, cnt_d;
  logic [PL_W-1:0]    win_len, last_idx;
  logic               s1_last, s1_advance, in_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ppu_quant_lane #(
      .DATA_BITS(DATA_BITS),
      .SHIFT_W  (SHIFT_W)
    ) u_quant (
      .data_i (in_data[i*DATA_BITS +: DATA_BITS]),
      .shift_i(scaling_factor),
      .q_o    (q_lane[i])
    );
  end

  always_comb begin
    win_len = PL_W'(1);
    if (maxpool_en && (pool_len != '0)) begin
      win_len = (pool_len > PL_W'(MAX_POOL)) ? PL_W'(MAX_POOL) : pool_len;
    end
  end

  assign last_idx = win_len - PL_W'(1);
  assign s1_last  = (cnt_q == last_idx);

  // Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready,
  // and out_data is held while out_valid && !out_ready. Only the window-closing beat needs the output slot.
  assign s1_advance = s1_valid_q && !flush && (!s1_last || !out_valid_q || out_ready);
  assign in_ready   = !rst && !flush && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < LANES; i++) pooled[i] = '0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (flush) begin
      s1_valid_d = 1'b0;
      cnt_d      = '0;
      for (int i = 0; i < LANES; i++) acc_d[i] = '0;
    end else begin
      if (s1_advance) begin
        s1_valid_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          pooled[i] = (cnt_q == '0) ? s1_q[i] : qmax(acc_q[i], s1_q[i]);
          if (s1_last) begin
            out_data_d[i*8 +: 8] = (relu_en && pooled[i][7]) ? 8'd0 : pooled[i];
          end else begin
            acc_d[i] = pooled[i];
          end
        end
        if (s1_last) begin
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + PL_W'(1);
        end
      end
      if (in_fire) begin
        s1_d       = q_lane;
        s1_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_q[i]  <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ppu_stream.sv
// Self-checking bench for ppu_stream: directed scenarios plus randomized windows scored against a reference model.
module tb_ppu_stream;

  localparam int LANES     = 4;
  localparam int DATA_BITS = 32;
  localparam int SHIFT_W   = 6;
  localparam int MAX_POOL  = 4;
  localparam int PL_W      = $clog2(MAX_POOL+1);
  localparam int IN_W      = LANES*DATA_BITS;
  localparam int OUT_W     = LANES*8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_W-1:0]     in_data = '0;
  logic [SHIFT_W-1:0]  scaling_factor = '0;
  logic                maxpool_en = 1'b0;
  logic [PL_W-1:0]     pool_len = '0;
  logic                relu_en = 1'b0;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_W-1:0]    out_data;

  int                  errors = 0;
  int                  checks = 0;
  logic [OUT_W-1:0]    exp_q[$];
  logic [OUT_W-1:0]    win_q[$];
  logic                held_valid = 1'b0;
  logic [OUT_W-1:0]    held_data = '0;
  logic                rand_bp = 1'b0;

  ppu_stream #(
    .LANES(LANES), .DATA_BITS(DATA_BITS), .SHIFT_W(SHIFT_W), .MAX_POOL(MAX_POOL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .scaling_factor(scaling_factor), .maxpool_en(maxpool_en), .pool_len(pool_len),
    .relu_en(relu_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  function automatic int eff_len();
    if (!maxpool_en || pool_len == '0) return 1;
    if (int'(pool_len) > MAX_POOL) return MAX_POOL;
    return int'(pool_len);
  endfunction

  function automatic logic [7:0] ref_quant(input longint v, input int sf);
    longint r;
    r = v;
`ifdef PPU_ROUND_EN
    if (sf > 0) r = r + (longint'(1) << (sf - 1));
`endif
    r = r >>> sf;
    if (r > 127) return 8'h7f;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  task automatic model_accept(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] qb;
    logic [OUT_W-1:0] res;
    logic [DATA_BITS-1:0] lane;
    int m;
    int v;
    for (int i = 0; i < LANES; i++) begin
      lane = d[i*DATA_BITS +: DATA_BITS];
      qb[i*8 +: 8] = ref_quant(longint'($signed(lane)), int'(scaling_factor));
    end
    win_q.push_back(qb);
    if (win_q.size() >= eff_len()) begin
      for (int i = 0; i < LANES; i++) begin
        m = -1000;
        for (int k = 0; k < win_q.size(); k++) begin
          v = $signed(win_q[k][i*8 +: 8]);
          if (v > m) m = v;
        end
        if (relu_en && m < 0) m = 0;
        res[i*8 +: 8] = 8'(m);
      end
      exp_q.push_back(res);
      win_q.delete();
    end
  endtask

  function automatic logic [IN_W-1:0] beat4(input int a, input int b, input int c, input int e);
    logic [IN_W-1:0] r;
    r[0*DATA_BITS +: DATA_BITS] = a;
    r[1*DATA_BITS +: DATA_BITS] = b;
    r[2*DATA_BITS +: DATA_BITS] = c;
    r[3*DATA_BITS +: DATA_BITS] = e;
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always begin
    logic [OUT_W-1:0] exp;
    @(negedge clk);
    #2;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h, need valid=1 data=%h", out_valid, out_data, held_data);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, need no output", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL output_data: got %h, need %h", out_data, exp);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic send_beat(input logic [IN_W-1:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (in_ready === 1'b1) begin
        model_accept(d);
        done = 1;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b, need 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      if (exp_q.size() == 0) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs, need 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h, need 0 0 0", in_ready, out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b, need 1 0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_quant();
    logic [7:0] exp0;
`ifdef PPU_ROUND_EN
    exp0 = 8'd20;
`else
    exp0 = 8'd19;
`endif
    maxpool_en = 1'b0; relu_en = 1'b0; scaling_factor = 6'd4; out_ready = 1'b1;
    send_beat(beat4(312, -312, 1000, 7));
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL quant_early: got out_valid=%b one edge after accept, need 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[7:0] !== exp0) begin
      errors++;
      $display("FAIL quant_lane0: got valid=%b lane0=%0d, need valid=1 lane0=%0d", out_valid, $signed(out_data[7:0]), $signed(exp0));
    end
    @(negedge clk);
  endtask

  task automatic test_saturate_relu();
    int          sf_t   [3] = '{0, 2, 2};
    bit          relu_t [3] = '{0, 0, 1};
    int          lane_t [3] = '{0, 1, 1};
    logic [7:0]  exp_t  [3] = '{8'h7f, 8'h80, 8'h00};
    logic [7:0]  got;
    maxpool_en = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      scaling_factor = SHIFT_W'(sf_t[k]);
      relu_en = relu_t[k];
      send_beat(beat4(4096, -5000, -3, 600));
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      got = out_data[lane_t[k]*8 +: 8];
      checks++;
      if (out_valid !== 1'b1 || got !== exp_t[k]) begin
        errors++;
        $display("FAIL sat_relu_%0d: got valid=%b lane%0d=%0d, need valid=1 %0d", k, out_valid, lane_t[k], $signed(got), $signed(exp_t[k]));
      end
      @(negedge clk);
    end
    relu_en = 1'b0;
  endtask

  task automatic test_pool();
    int seq [4] = '{3, -7, 9, 2};
    maxpool_en = 1'b1; pool_len = PL_W'(4); scaling_factor = '0; relu_en = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_beat(beat4(seq[k], -k, 100 - k, $urandom_range(0, 50)));
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pool_early_%0d: got out_valid=%b, need 0", k, out_valid);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[7:0] !== 8'd9) begin
      errors++;
      $display("FAIL pool_result: got valid=%b lane0=%0d, need valid=1 lane0=9", out_valid, $signed(out_data[7:0]));
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pool_single: got out_valid=%b after consume, need 0", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    maxpool_en = 1'b0; scaling_factor = '0; relu_en = 1'b0;
    fork
      begin
        send_beat(beat4(10, 1, 2, 3));
        send_beat(beat4(20, 4, 5, 6));
        send_beat(beat4(30, 7, 8, 9));
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data[7:0] !== 8'd10) begin
          errors++;
          $display("FAIL backpressure: got ready=%b valid=%b lane0=%0d, need 0 1 10", in_ready, out_valid, $signed(out_data[7:0]));
        end
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_flush();
    maxpool_en = 1'b1; pool_len = PL_W'(4); scaling_factor = '0; relu_en = 1'b0; out_ready = 1'b1;
    send_beat(beat4(50, 50, 50, 50));
    send_beat(beat4(60, 60, 60, 60));
    in_data = beat4(99, 99, 99, 99);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got in_ready=%b with flush, need 0", in_ready);
    end
    win_q.delete();
    @(negedge clk);
    flush = 1'b0;
    for (int k = 1; k <= 4; k++) send_beat(beat4(k, -k, 5 - k, 0));
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[7:0] !== 8'd4) begin
      errors++;
      $display("FAIL flush_window: got valid=%b lane0=%0d, need valid=1 lane0=4", out_valid, $signed(out_data[7:0]));
    end
    @(negedge clk);
    wait_drain();
  endtask

  task automatic test_async_reset();
    maxpool_en = 1'b1; pool_len = PL_W'(3); scaling_factor = '0; relu_en = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_beat(beat4(100 + k, k, -k, 1));
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    exp_q.delete();
    win_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b data=%h, need 0 0 0", out_valid, in_ready, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 5; k <= 7; k++) send_beat(beat4(k, -k, 0, k * 3));
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data[7:0] !== 8'd7) begin
      errors++;
      $display("FAIL reset_recover: got valid=%b lane0=%0d, need valid=1 lane0=7", out_valid, $signed(out_data[7:0]));
    end
    @(negedge clk);
    wait_drain();
  endtask

  task automatic test_random();
    logic [IN_W-1:0] d;
    int len;
    rand_bp = 1'b1;
    for (int w = 0; w < 30; w++) begin
      wait_drain();
      maxpool_en     = 1'($urandom_range(0, 1));
      pool_len       = PL_W'($urandom_range(0, (1 << PL_W) - 1));
      scaling_factor = SHIFT_W'($urandom_range(0, 12));
      relu_en        = 1'($urandom_range(0, 1));
      len = eff_len();
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 2))
            0:       d[i*DATA_BITS +: DATA_BITS] = DATA_BITS'(int'($urandom_range(0, 4000)) - 2000);
            1:       d[i*DATA_BITS +: DATA_BITS] = DATA_BITS'(int'($urandom_range(0, 400000)) - 200000);
            default: d[i*DATA_BITS +: DATA_BITS] = DATA_BITS'($urandom);
          endcase
        end
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
        send_beat(d);
      end
      in_valid = 1'b0;
    end
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_quant();
    test_saturate_relu();
    test_pool();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outputs outstanding, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
